// File: rtl/labyrinth_ram_arbiter_pkg.sv
// Shared widths and arbiter state encoding, also used by game_control and vga_control.
package labyrinth_ram_arbiter_pkg;

  localparam int ADDR_W = 13;  // {room[4:0], row[1:0], col[5:0]}
  localparam int CHAR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating up-counter with synchronous clear; flags when the starvation limit is reached.
module arb_starve_counter #(
  parameter int CW    = 7,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);
  localparam logic [CW-1:0] MAX_V   = '1;

  logic [CW-1:0] count;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)                       count <= '0;
    else if (clr)                     count <= '0;
    else if (inc && (count != MAX_V)) count <= count + CW'(1);
  end

  assign terminal = (count == LIMIT_V);

endmodule

// File: rtl/labyrinth_ram_arbiter.sv
// Shares the labyrinth_ram read port: VGA fetch has priority, game lookups fill idle
// cycles, and a starvation counter forces a lookup in during long active-video runs.
module labyrinth_ram_arbiter
  import labyrinth_ram_arbiter_pkg::*;
#(
  parameter int AW           = ADDR_W,
  parameter int DW           = CHAR_W,
  parameter int STARVE_LIMIT = 64,
  parameter int CW           = 7
) (
  input  logic          clk_50MHz_i,
  input  logic          rst_async_la_i,
  input  logic          vga_active_i,
  input  logic [AW-1:0] vga_addr_i,
  output logic [DW-1:0] vga_data_o,
  output logic          vga_stolen_o,
  input  logic          ctl_req_i,
  input  logic [AW-1:0] ctl_addr_i,
  output logic [DW-1:0] ctl_data_o,
  output logic          ctl_ack_o,
  output logic [AW-1:0] ram_addr_o,
  input  logic [DW-1:0] ram_data_i
);

  arb_state_e    state, state_nxt;
  logic [AW-1:0] addr_q;
  logic          starve_hit;
  logic          grant;
  logic          starve_inc;

  // Gated by reset so the VGA keeps the port even if the FSM is undefined before reset.
  assign grant      = rst_async_la_i && (state == ST_ISSUE) && (!vga_active_i || starve_hit);
  assign starve_inc = rst_async_la_i && (state == ST_ISSUE) && !grant;

  arb_starve_counter #(
    .CW    (CW),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk_50MHz_i),
    .rst_n    (rst_async_la_i),
    .clr      (grant),
    .inc      (starve_inc),
    .terminal (starve_hit)
  );

  always_ff @(posedge clk_50MHz_i) begin
    if (!rst_async_la_i) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  // NOTE: default assigned first so no path through this block can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ctl_req_i) state_nxt = ST_ISSUE;
      ST_ISSUE: if (grant)     state_nxt = ST_WAIT;
      ST_WAIT:                 state_nxt = ST_ACK;
      ST_ACK:                  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: addr_q is left out of reset; it is only read after IDLE has reloaded it.
  always_ff @(posedge clk_50MHz_i) begin
    if ((state == ST_IDLE) && ctl_req_i) addr_q <= ctl_addr_i;
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (!rst_async_la_i) begin
      ctl_data_o   <= '0;
      vga_stolen_o <= 1'b0;
    end else begin
      vga_stolen_o <= grant && vga_active_i;
      if (state == ST_WAIT) ctl_data_o <= ram_data_i;
    end
  end

  assign ctl_ack_o  = (state == ST_ACK);
  assign ram_addr_o = grant ? addr_q : vga_addr_i;
  assign vga_data_o = ram_data_i;

endmodule

// File: tb/tb_labyrinth_ram_arbiter.sv
// Self-checking bench for labyrinth_ram_arbiter: a behavioural RAM plus a per-lookup
// model that predicts the grant cycle from the VGA activity pattern.
module tb_labyrinth_ram_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LIMIT = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_active;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_stolen;
  logic          ctl_req;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_data;
  logic          ctl_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;

  logic [DW-1:0] mem [2**AW];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  labyrinth_ram_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .CW(7)
  ) dut (
    .clk_50MHz_i    (clk),
    .rst_async_la_i (rst_n),
    .vga_active_i   (vga_active),
    .vga_addr_i     (vga_addr),
    .vga_data_o     (vga_data),
    .vga_stolen_o   (vga_stolen),
    .ctl_req_i      (ctl_req),
    .ctl_addr_i     (ctl_addr),
    .ctl_data_o     (ctl_data),
    .ctl_ack_o      (ctl_ack),
    .ram_addr_o     (ram_addr),
    .ram_data_i     (ram_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_data <= mem[ram_addr];
    cyc      <= cyc + 1;
  end

  // Activity pattern: 0 idle, 1 continuous video, 2 toggling, 3 mostly active random.
  function automatic logic pick_active(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cyc[0];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ctl_req    = 1'b0;
      vga_active = 1'($urandom_range(0, 1));
      vga_addr   = AW'($urandom);
      #1;
      n_checks++;
      if (ram_addr !== vga_addr) begin
        n_fail++; $display("FAIL idle ram_addr: got %h expected %h", ram_addr, vga_addr);
      end
      n_checks++;
      if (ctl_ack !== 1'b0 || vga_stolen !== 1'b0) begin
        n_fail++; $display("FAIL idle ack/stolen: got %b/%b expected 0/0", ctl_ack, vga_stolen);
      end
      n_checks++;
      if (vga_data !== ram_data) begin
        n_fail++; $display("FAIL idle vga_data: got %h expected %h", vga_data, ram_data);
      end
    end
  endtask

  // One lookup from IDLE to ACK. The model grants on the k-th ISSUE cycle when VGA is
  // idle or k has reached the starvation limit; ack follows two cycles after the grant.
  task automatic do_lookup(input logic [AW-1:0] addr, input int mode, input bit drop,
                           input string name);
    int   k;
    logic act;
    logic granted;
    logic stolen_exp;
    @(negedge clk);
    ctl_req    = 1'b1;
    ctl_addr   = addr;
    vga_active = pick_active(mode);
    vga_addr   = AW'($urandom);
    #1;
    n_checks++;
    if (ram_addr !== vga_addr || ctl_ack !== 1'b0) begin
      n_fail++; $display("FAIL %s req cycle: ram_addr %h ack %b, expected %h ack 0",
                         name, ram_addr, ctl_ack, vga_addr);
    end
    k          = 0;
    granted    = 1'b0;
    stolen_exp = 1'b0;
    while (!granted) begin
      @(negedge clk);
      if (drop) begin
        ctl_req  = 1'b0;
        ctl_addr = AW'($urandom);
      end
      act        = pick_active(mode);
      vga_active = act;
      vga_addr   = AW'($urandom);
      #1;
      granted    = !act || (k == LIMIT);
      stolen_exp = act;
      n_checks++;
      if (ram_addr !== (granted ? addr : vga_addr)) begin
        n_fail++; $display("FAIL %s issue k=%0d ram_addr: got %h expected %h",
                           name, k, ram_addr, granted ? addr : vga_addr);
      end
      n_checks++;
      if (ctl_ack !== 1'b0 || vga_stolen !== 1'b0) begin
        n_fail++; $display("FAIL %s issue k=%0d ack/stolen: got %b/%b expected 0/0",
                           name, k, ctl_ack, vga_stolen);
      end
      k++;
    end
    @(negedge clk);
    vga_active = pick_active(mode);
    vga_addr   = AW'($urandom);
    #1;
    n_checks++;
    if (vga_stolen !== stolen_exp) begin
      n_fail++; $display("FAIL %s stolen: got %b expected %b", name, vga_stolen, stolen_exp);
    end
    n_checks++;
    if (vga_data !== mem[addr] || ram_addr !== vga_addr || ctl_ack !== 1'b0) begin
      n_fail++; $display("FAIL %s wait: vga_data %h ram_addr %h ack %b, expected %h %h 0",
                         name, vga_data, ram_addr, ctl_ack, mem[addr], vga_addr);
    end
    @(negedge clk);
    vga_active = pick_active(mode);
    vga_addr   = AW'($urandom);
    #1;
    n_checks++;
    if (ctl_ack !== 1'b1) begin
      n_fail++; $display("FAIL %s ack: got %b expected 1", name, ctl_ack);
    end
    n_checks++;
    if (ctl_data !== mem[addr]) begin
      n_fail++; $display("FAIL %s data: got %h expected %h", name, ctl_data, mem[addr]);
    end
    n_checks++;
    if (vga_stolen !== 1'b0 || ram_addr !== vga_addr) begin
      n_fail++; $display("FAIL %s ack cycle: stolen %b ram_addr %h, expected 0 %h",
                         name, vga_stolen, ram_addr, vga_addr);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ctl_req  = 1'b1;
    ctl_addr = 13'h0A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vga_active = 1'($urandom_range(0, 1));
      vga_addr   = AW'($urandom);
      #1;
      n_checks++;
      if (ctl_ack !== 1'b0 || ctl_data !== '0 || vga_stolen !== 1'b0) begin
        n_fail++; $display("FAIL reset outputs: ack %b data %h stolen %b, expected 0 00 0",
                           ctl_ack, ctl_data, vga_stolen);
      end
      n_checks++;
      if (ram_addr !== vga_addr) begin
        n_fail++; $display("FAIL reset ram_addr: got %h expected %h", ram_addr, vga_addr);
      end
    end
    @(negedge clk);
    rst_n   = 1'b1;
    ctl_req = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    do_lookup(13'h0A5, 0, 1'b0, "basic");
    idle_cycles(2);
  endtask

  task automatic test_starve();
    do_lookup(AW'($urandom), 1, 1'b0, "starve1");
    do_lookup(AW'($urandom), 1, 1'b0, "starve2");
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) do_lookup(AW'($urandom), 2, 1'b0, "toggle");
    idle_cycles(1);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    ctl_req    = 1'b1;
    ctl_addr   = 13'h1234;
    vga_active = 1'b0;
    vga_addr   = AW'($urandom);
    @(negedge clk);
    vga_addr = AW'($urandom);
    #1;
    n_checks++;
    if (ram_addr !== 13'h1234) begin
      n_fail++; $display("FAIL rst_wait grant: got %h expected 1234", ram_addr);
    end
    @(negedge clk);
    rst_n   = 1'b0;
    ctl_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctl_ack !== 1'b0 || ctl_data !== '0 || vga_stolen !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait outputs: ack %b data %h stolen %b, expected 0 00 0",
                         ctl_ack, ctl_data, vga_stolen);
    end
    idle_cycles(2);
    do_lookup(13'h0777, 3, 1'b0, "after_rst");
    idle_cycles(1);
  endtask

  task automatic test_drop();
    do_lookup(13'h0042, 0, 1'b1, "drop_idle");
    do_lookup(13'h1ABC, 3, 1'b1, "drop_busy");
    idle_cycles(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      idle_cycles($urandom_range(0, 3));
      do_lookup(AW'($urandom), 3, ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'((i * 37 + 11) % 255 + 1);
    mem[13'h0A5] = 8'h23;
    vga_active   = 1'b0;
    vga_addr     = '0;
    test_reset();
    test_basic();
    test_starve();
    test_back_to_back();
    test_reset_in_wait();
    test_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
